// File: rtl/event_ingress_fifo.sv
// Ingress buffer for raw sensor events: filters out-of-range or time-reversed events,
// packs them into 72-bit words and hands them to the graph core through a FWFT FIFO.
module event_ingress_fifo #(
  parameter int unsigned FIFO_WIDTH = 72,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned X_MAX      = 239,
  parameter int unsigned Y_MAX      = 179
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [15:0]           in_x,
  input  logic [15:0]           in_y,
  input  logic [31:0]           in_ts,
  input  logic                  in_pol,
  input  logic                  stream_end,
  input  logic                  restart,
  output logic                  data_valid,
  output logic [FIFO_WIDTH-1:0] new_event,
  input  logic                  module_ready,
  output logic                  stream_done,
  output logic [15:0]           drop_cnt,
  output logic [31:0]           evt_cnt
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [15:0] X_LIM   = 16'(X_MAX);
  localparam logic [15:0] Y_LIM   = 16'(Y_MAX);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic [AW:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                    in_ready_q, in_ready_d;
  logic [15:0]             drop_cnt_q, drop_cnt_d;
  logic [31:0]             evt_cnt_q, evt_cnt_d;
  logic [31:0]             last_ts_q, last_ts_d;
  logic [FIFO_WIDTH-1:0]   mem_q [DEPTH];
  logic [FIFO_WIDTH-1:0]   wr_word;
  logic                    empty, full, empty_d, full_d;
  logic                    push_acc, bad_evt, wr_en, rd_en;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic ptr_full(input logic [AW:0] wp, input logic [AW:0] rp);
    return (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  endfunction

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = ptr_full(wr_ptr_q, rd_ptr_q);
    wr_word  = {in_ts, in_x, in_y, 7'b0, in_pol};
    // in_ready_q already implies RUN and not full, so no extra qualification here
    push_acc = in_valid & in_ready_q;
    bad_evt  = (in_x > X_LIM) | (in_y > Y_LIM) | (in_ts < last_ts_q);
    wr_en    = push_acc & ~bad_evt;
    rd_en    = ~empty & module_ready;
    wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = ptr_full(wr_ptr_d, rd_ptr_d);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (stream_end) state_d = S_DRAIN;
      // Looking at the post-update occupancy lets DONE coincide with the FIFO going empty
      S_DRAIN: if (empty_d)    state_d = S_DONE;
      S_DONE:  if (restart)    state_d = S_RUN;
      default:                 state_d = S_RUN;
    endcase
  end

  always_comb begin
    last_ts_d  = last_ts_q;
    drop_cnt_d = drop_cnt_q;
    evt_cnt_d  = evt_cnt_q;
    if (wr_en)               last_ts_d  = in_ts;
    if (push_acc && bad_evt) drop_cnt_d = sat_inc16(drop_cnt_q);
    if (rd_en)               evt_cnt_d  = evt_cnt_q + 32'd1;
    if (state_q == S_DONE && restart) begin
      last_ts_d  = '0;
      drop_cnt_d = '0;
      evt_cnt_d  = '0;
    end
    in_ready_d = (state_d == S_RUN) && !full_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_RUN;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      in_ready_q <= 1'b0;
      drop_cnt_q <= '0;
      evt_cnt_q  <= '0;
      last_ts_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      in_ready_q <= in_ready_d;
      drop_cnt_q <= drop_cnt_d;
      evt_cnt_q  <= evt_cnt_d;
      last_ts_q  <= last_ts_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_word;
  end

  // Head word is forced to zero when empty so the output reads 0 during reset
  always_comb begin
    in_ready    = in_ready_q;
    stream_done = (state_q == S_DONE);
    data_valid  = ~empty;
    new_event   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    drop_cnt    = drop_cnt_q;
    evt_cnt     = evt_cnt_q;
  end

endmodule
